keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad and debounces it into single-cycle key events. Digit keys assemble a 4-digit BCD entry register whose 16-bit output drives the board's multiplexed seven-segment display controller directly. Together with that controller, it forms the input half of the front-panel user interface.

## Interface
- SCAN_BITS, 16: row dwell is 2^SCAN_BITS clk cycles.
- DEBOUNCE, 4: consecutive identical full-matrix frames required to accept a press or a release (1..15).

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- col_n  in  4  keypad columns, active-low, externally pulled up, asynchronous
- row_n  out  4  row strobes, one-hot active-low
- key_valid  out  1  one-cycle pulse per accepted press
- key_code  out  4  code of the last accepted key, held between pulses
- value  out  16  BCD entry register; value[3:0] is the newest digit

## Operation
- Keymap, with row r and column c, index 4r+c, row 0 on top:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
  - Codes: digits map to themselves, A-D map to 0xA-0xD, * maps to 0xE, # maps to 0xF.
- Input synchronisation: col_n passes through a 2-flop synchroniser before any use.
- Scan sequence:
  - row_n cycles 1110, 1101, 1011, 0111, then wraps.
  - The dwell counter advances every cycle.
  - On the last cycle of each dwell (counter all ones), the synchronised columns for the current row are latched.
- Frame result, produced after row 3 is latched:
  - NONE: no column is low.
  - SINGLE(code): exactly one key is down across the whole frame.
  - MULTI: two or more keys are down.
- State machine, evaluated once per frame:
  - IDLE: on SINGLE(k), set cand=k and cnt=1, go to PRESS_CHK. On NONE or MULTI, stay.
  - PRESS_CHK:
    - SINGLE(cand) increments cnt. When cnt reaches DEBOUNCE, accept the key and go to HELD.
    - SINGLE(other) restarts with cand=other and cnt=1.
    - NONE or MULTI returns to IDLE.
  - HELD: on NONE, set cnt=1 and go to REL_CHK. SINGLE and MULTI stay (no auto-repeat).
  - REL_CHK: NONE increments cnt; when cnt reaches DEBOUNCE, go to IDLE. Any key returns to HELD.
- Accepting a key:
  - key_valid=1 for one cycle and key_code=cand.
  - For digits 0-9, value <= {value[11:0], cand}. The oldest digit is discarded.
  - For 0xE (*), value <= 0.
  - For 0xF (#), value <= {4'h0, value[15:4]}, deleting the newest digit.
  - For 0xA-0xD, value is unchanged.
- value therefore only ever holds BCD digits 0-9 per nibble.

## Timing
- Reset values:
  - row_n=1110, key_valid=0, key_code=0, value=0.
  - Dwell counter=0, row index=0, state=IDLE, cnt=0.
  - Synchroniser flops are set to 1111.
- The row changes on the cycle after a dwell's final cycle. Frame length is 4*2^SCAN_BITS cycles.
- Frame evaluation occurs on the clock edge that latches row 3.
  - key_valid, key_code and value all update on that same edge, so they are visible in the following cycle.
- Press latency, from a stable press to the key_valid pulse: between (DEBOUNCE-1) and DEBOUNCE full frames after the first frame that sees the key, plus 2 synchroniser cycles.
- The dwell counter and row index wrap freely.
- Reset asserted mid-frame or mid-debounce discards partial frame data and returns to the reset values on the next edge.
- A key held through reset release must pass full debounce again before it is reported.
- key_valid is never asserted on two consecutive cycles.

## Structure
- Package keypad_pkg contains:
  - State enum {IDLE, PRESS_CHK, HELD, REL_CHK}.
  - Frame-result encoding {NONE, SINGLE, MULTI}.
  - Key code constants KEY_STAR=4'hE and KEY_HASH=4'hF.
  - A function mapping the 4-bit row/column index to a key code.
- The top level (keypad_scanner) owns the synchroniser, the dwell/row counters, frame collection and the value register.
- Sub-module keypad_debounce holds the state machine and cnt. It takes the frame result plus a frame strobe and emits the accept pulse and code.

## Test plan
All scenarios use SCAN_BITS=2, giving a 4-cycle dwell and a 16-cycle frame, with DEBOUNCE=3.
- Reset, then idle with col_n=1111 -> row_n steps through 1110, 1101, 1011, 0111 every 4 cycles; key_valid stays 0; value=0.
- Press "5" (pull col 1 low while row 1 is strobed) for 5 frames, then release -> exactly one key_valid pulse with key_code=5 and value=0x0005. No pulse on release.
- Press 1, 2, 3, 4, 9 in sequence with full releases between -> value=0x2349. Then press # -> value=0x0234. Then press * -> value=0.
- A key that bounces (pressed 2 frames, released 1 frame, repeated) -> no key_valid. Holding "7" for 20 frames -> one pulse only.
- Keys "1" and "6" held together -> no pulse. Releasing "6" while keeping "1" held -> a pulse with key_code=1 after DEBOUNCE frames.
- Assert rst during PRESS_CHK with cnt=2 while the key is still held -> no pulse. After reset, a press is reported only after 3 further frames, and value=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Index is 4*row + col with row 0 on top of the keypad.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'h0;
      4'd14:   code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce state machine: turns a stream of per-frame results into accept pulses.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_strobe,
  input  frame_t     frame_res,
  input  logic [3:0] frame_code,
  output logic       accept,
  output logic [3:0] accept_code
);

  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] cand, cand_nx;
  logic [3:0] cnt_inc;

  assign cnt_inc     = cnt + 4'd1;
  assign accept_code = frame_code;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    if (frame_strobe) begin
      case (state)
        IDLE: begin
          if (frame_res == SINGLE) begin
            cand_nx = frame_code;
            cnt_nx  = 4'd1;
            if (DB_LIM <= 4'd1) begin
              accept   = 1'b1;
              state_nx = HELD;
            end else begin
              state_nx = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (frame_res == SINGLE) begin
            if (frame_code == cand) begin
              cnt_nx = cnt_inc;
              if (cnt_inc >= DB_LIM) begin
                accept   = 1'b1;
                state_nx = HELD;
              end
            end else begin
              cand_nx = frame_code;
              cnt_nx  = 4'd1;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        HELD: begin
          // Holding a key never repeats; only a clean release frame moves on.
          if (frame_res == NONE) begin
            cnt_nx   = 4'd1;
            state_nx = (DB_LIM <= 4'd1) ? IDLE : REL_CHK;
          end
        end
        REL_CHK: begin
          if (frame_res == NONE) begin
            cnt_nx = cnt_inc;
            if (cnt_inc >= DB_LIM) state_nx = IDLE;
          end else begin
            state_nx = HELD;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cand  <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobing, column sampling, frame classification and BCD entry register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS = 16,
  parameter int DEBOUNCE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] value
);

  logic [3:0]           sync1, sync2;
  logic [SCAN_BITS-1:0] dwell;
  logic [1:0]           row_idx;
  logic [11:0]          frame_bits;
  logic                 dwell_last;
  logic                 frame_strobe;
  logic [15:0]          matrix;
  logic [4:0]           n_keys;
  logic [3:0]           hit_idx;
  frame_t               frame_res;
  logic [3:0]           frame_code;
  logic                 accept;
  logic [3:0]           accept_code;

  assign dwell_last   = &dwell;
  assign frame_strobe = dwell_last && (row_idx == 2'd3);

  always_comb begin
    row_n = 4'b1111;
    row_n[row_idx] = 1'b0;
  end

  // Row 3 is classified straight from the synchroniser on the edge that would latch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 4'hF;
      sync2      <= 4'hF;
      dwell      <= '0;
      row_idx    <= 2'd0;
      frame_bits <= 12'd0;
    end else begin
      sync1 <= col_n;
      sync2 <= sync1;
      dwell <= dwell + 1'b1;
      if (dwell_last) begin
        row_idx <= row_idx + 2'd1;
        case (row_idx)
          2'd0:    frame_bits[3:0]  <= ~sync2;
          2'd1:    frame_bits[7:4]  <= ~sync2;
          2'd2:    frame_bits[11:8] <= ~sync2;
          default: ;
        endcase
      end
    end
  end

  assign matrix = {~sync2, frame_bits};

  always_comb begin
    n_keys  = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (matrix[i]) begin
        n_keys  = n_keys + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (n_keys == 5'd0)      frame_res = NONE;
    else if (n_keys == 5'd1) frame_res = SINGLE;
    else                     frame_res = MULTI;
    frame_code = key_map(hit_idx);
  end

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_strobe (frame_strobe),
    .frame_res    (frame_res),
    .frame_code   (frame_code),
    .accept       (accept),
    .accept_code  (accept_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      value     <= 16'd0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= accept_code;
        if (accept_code <= 4'd9)          value <= {value[11:0], accept_code};
        else if (accept_code == KEY_STAR) value <= 16'd0;
        else if (accept_code == KEY_HASH) value <= {4'h0, value[15:4]};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a 16-cycle frame and DEBOUNCE=3.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;

  logic [15:0] keys;
  int          checks;
  int          failures;
  int          pulses;
  int          consec;
  logic        prev_valid;
  logic [3:0]  last_code;

  keypad_scanner #(
    .SCAN_BITS (2),
    .DEBOUNCE  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row strobe onto its column.
  assign col_n = ~(({4{~row_n[0]}} & keys[3:0])  | ({4{~row_n[1]}} & keys[7:4]) |
                   ({4{~row_n[2]}} & keys[11:8]) | ({4{~row_n[3]}} & keys[15:12]));

  initial begin
    pulses     = 0;
    consec     = 0;
    prev_valid = 1'b0;
    last_code  = 4'd0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses    = pulses + 1;
      last_code = key_code;
      if (prev_valid) consec = consec + 1;
    end
    prev_valid = key_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int frames);
    keys = k;
    repeat (frames * 16) @(negedge clk);
  endtask

  task automatic pressRelease(input int idx, input logic [3:0] code, input logic [15:0] exp_value);
    int base;
    base = pulses;
    applyStimulus(16'(1) << idx, 5);
    checkOutput("press_pulse", 32'(pulses - base), 32'd1);
    applyStimulus(16'd0, 5);
    checkOutput("release_no_pulse", 32'(pulses - base), 32'd1);
    checkOutput("press_code", 32'(last_code), 32'(code));
    checkOutput("press_value", 32'(value), 32'(exp_value));
  endtask

  initial begin
    int   base;
    logic found;
    logic [3:0] prev_row;
    checks   = 0;
    failures = 0;
    keys     = 16'd0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_row_n", 32'(row_n), 32'h0000000E);
    checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_key_code", 32'(key_code), 32'd0);
    checkOutput("rst_value", 32'(value), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_row;
      exp_row = 4'b1111;
      exp_row[i / 4] = 1'b0;
      checkOutput("scan_row_n", 32'(row_n), 32'(exp_row));
      @(negedge clk);
    end

    base = pulses;
    applyStimulus(16'd0, 3);
    checkOutput("idle_no_pulse", 32'(pulses - base), 32'd0);
    checkOutput("idle_value", 32'(value), 32'd0);

    pressRelease(5, 4'h5, 16'h0005);
    checkOutput("held_key_code", 32'(key_code), 32'h5);

    pressRelease(0, 4'h1, 16'h0051);
    pressRelease(1, 4'h2, 16'h0512);
    pressRelease(2, 4'h3, 16'h5123);
    pressRelease(4, 4'h4, 16'h1234);
    pressRelease(10, 4'h9, 16'h2349);
    pressRelease(14, 4'hF, 16'h0234);
    pressRelease(12, 4'hE, 16'h0000);

    base = pulses;
    repeat (4) begin
      applyStimulus(16'h0100, 2);
      applyStimulus(16'h0000, 1);
    end
    applyStimulus(16'h0000, 4);
    checkOutput("bounce_no_pulse", 32'(pulses - base), 32'd0);

    base = pulses;
    applyStimulus(16'h0100, 20);
    applyStimulus(16'h0000, 5);
    checkOutput("hold7_one_pulse", 32'(pulses - base), 32'd1);
    checkOutput("hold7_code", 32'(last_code), 32'h7);
    checkOutput("hold7_value", 32'(value), 32'h0007);

    pressRelease(3, 4'hA, 16'h0007);

    base = pulses;
    applyStimulus(16'h0041, 5);
    checkOutput("multi_no_pulse", 32'(pulses - base), 32'd0);
    applyStimulus(16'h0001, 6);
    checkOutput("multi_release_pulse", 32'(pulses - base), 32'd1);
    checkOutput("multi_release_code", 32'(last_code), 32'h1);
    applyStimulus(16'h0000, 5);
    checkOutput("multi_value", 32'(value), 32'h0071);

    found    = 1'b0;
    prev_row = row_n;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_n == 4'b1110 && prev_row != 4'b1110) found = 1'b1;
      prev_row = row_n;
    end
    checkOutput("frame_align", 32'(found), 32'd1);

    base = pulses;
    keys = 16'h0020;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_mid_no_pulse", 32'(pulses - base), 32'd0);
    checkOutput("rst_mid_value", 32'(value), 32'd0);
    rst = 1'b0;
    repeat (36) @(negedge clk);
    checkOutput("post_rst_early", 32'(pulses - base), 32'd0);
    repeat (24) @(negedge clk);
    checkOutput("post_rst_pulse", 32'(pulses - base), 32'd1);
    checkOutput("post_rst_code", 32'(last_code), 32'h5);
    checkOutput("post_rst_value", 32'(value), 32'h0005);
    applyStimulus(16'h0000, 5);

    checkOutput("no_back_to_back", 32'(consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
